// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings for the data-phase return path.
//   HTRANS_*    : master transfer type encodings
//   HRESP_*     : slave response encodings
//   ds_state_t  : default-slave response sequencer states
//   htrans_active() : true for the transfer types that need a real response
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // IDLE and BUSY get a zero-wait OKAY from every slave; only NONSEQ/SEQ
  // carry data and therefore need the full response.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Answers accesses that matched no slave (or matched several) with the
// two-cycle AHB ERROR response: one wait cycle with ERROR, then a ready
// cycle with ERROR.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   HSEL          : address-phase select of the default slave
//   HTRANS        : master transfer type
//   HREADY        : bus-level ready (transfer is sampled when high)
//   HREADYOUT     : this slave's ready
//   HRESP         : this slave's response
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_t state_reg;
  ds_state_t state_next;
  logic      accept;

  // A transfer is only taken on a cycle where the bus is ready; IDLE/BUSY
  // addressed here never start the error sequence.
  assign accept = HREADY & HSEL & htrans_active(HTRANS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= DS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    case (state_reg)
      DS_IDLE: begin
        if (accept) begin
          state_next = DS_ERR1;
        end
      end
      DS_ERR1: begin
        // Wait cycle: the master sees ERROR early and may cancel the next
        // transfer, but the second cycle is always completed.
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP = HRESP_ERROR;
        // HREADY is high here, so the next address phase is sampled now;
        // a back-to-back error transfer skips the OKAY cycle.
        state_next = accept ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        state_next = DS_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_resp_mux
// Data-phase return path of the AHB interconnect. Registers the decoder's
// address-phase selects into the data phase and muxes the selected slave's
// HRDATA/HREADYOUT/HRESP back to the master. Unmapped or multiply-decoded
// accesses are routed to an embedded default slave that returns ERROR.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   HSELx         : address-phase one-hot slave selects (NSLV)
//   HSEL_DEF      : address-phase "no slave matched"
//   HTRANS        : master transfer type
//   HRDATA_S      : slave read data, slave s at [s*DW +: DW]
//   HREADYOUT_S   : per-slave ready
//   HRESP_S       : per-slave response
//   HRDATA        : muxed read data
//   HREADY        : muxed ready (also broadcast to the slaves)
//   HRESP         : muxed response
// ---------------------------------------------------------------------------
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int NSLV = 4,
  parameter int DW   = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [NSLV-1:0]     HSELx,
  input  logic                HSEL_DEF,
  input  logic [1:0]          HTRANS,
  input  logic [NSLV*DW-1:0]  HRDATA_S,
  input  logic [NSLV-1:0]     HREADYOUT_S,
  input  logic [NSLV-1:0]     HRESP_S,
  output logic [DW-1:0]       HRDATA,
  output logic                HREADY,
  output logic                HRESP
);

  // dsel_reg[NSLV] is the default slave, bits [NSLV-1:0] the real slaves.
  logic [NSLV:0]   dsel_reg;
  logic [NSLV:0]   dsel_next;
  logic            multi;
  logic            def_sel;
  logic            def_readyout;
  logic            def_resp;

  logic [DW-1:0]   data_term [NSLV];
  logic [NSLV-1:0] ready_term;
  logic [NSLV-1:0] resp_term;
  logic [DW-1:0]   rdata_or;

  // Clearing the lowest set bit leaves something only if two or more bits
  // were set.
  assign multi   = |(HSELx & (HSELx - NSLV'(1)));
  assign def_sel = HSEL_DEF | multi;

  // Wait states extend the data phase, so selects are only captured on a
  // ready cycle.
  assign dsel_next = HREADY ? {def_sel, HSELx & {NSLV{~multi}}} : dsel_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_reg <= '0;
    end else begin
      dsel_reg <= dsel_next;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (def_sel),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (def_readyout),
    .HRESP     (def_resp)
  );

  // AND-OR mux: dsel_reg is one-hot or zero, so each slave is gated by its
  // own select bit and the terms are simply OR-ed together.
  for (genvar gi = 0; gi < NSLV; gi++) begin : g_slave_term
    assign data_term[gi]  = {DW{dsel_reg[gi]}} & HRDATA_S[gi*DW +: DW];
    assign ready_term[gi] = dsel_reg[gi] & HREADYOUT_S[gi];
    assign resp_term[gi]  = dsel_reg[gi] & HRESP_S[gi];
  end

  always_comb begin
    rdata_or = '0;
    for (int i = 0; i < NSLV; i++) begin
      rdata_or = rdata_or | data_term[i];
    end
  end

  // No selected slave means no data phase in progress: ready, OKAY, zero.
  // The default slave never drives read data.
  assign HRDATA = rdata_or;
  assign HREADY = ~(|dsel_reg) | (|ready_term) | (dsel_reg[NSLV] & def_readyout);
  assign HRESP  = (|resp_term) | (dsel_reg[NSLV] & def_resp);

  // An active transfer that decodes to nothing at all is a decoder bug; the
  // bus still completes it as a zero-wait OKAY.
  a_decoder_fault : assert property (
    @(posedge HCLK) disable iff (!HRESETn)
      !(HREADY && htrans_active(HTRANS) && (HSELx == '0) && !HSEL_DEF)
  );

  a_dsel_onehot0 : assert property (
    @(posedge HCLK) disable iff (!HRESETn) $onehot0(dsel_reg)
  );

  a_dsel_hold : assert property (
    @(posedge HCLK) disable iff (!HRESETn) !HREADY |=> $stable(dsel_reg)
  );

endmodule
